iob_native_ram_responder: RTL and testbench

Responder (target) end of the IOb native request/response bus: accepts one request at a time from an initiator such as the CPU wrapper's instruction or data bus and serves it from an internal word-addressed RAM with byte-enable writes. The access latency is set by a parameter. The block is a drop-in memory/peripheral model for SoC integration and for CPU-wrapper benches. It answers every accepted request, read or write, with a single-cycle `rvalid` pulse.

---
 rtl/iob_native_ram_responder_if.sv | 16 +
 rtl/iob_native_ram_responder.sv | 129 ++++++++++++
 tb/tb_iob_native_ram_responder.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iob_native_ram_responder_if.sv
// IOb native request/response bundle between an initiator and a RAM responder.
// The request is packed MSB-first as {avalid, addr, wdata, wstrb}; the response as {rdata, rvalid, ready}.
interface iob_native_ram_responder_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int REQ_W  = 1 + ADDR_W + DATA_W + DATA_W / 8;
   localparam int RESP_W = DATA_W + 2;

   logic [REQ_W-1:0]  req;
   logic [RESP_W-1:0] resp;
   logic              err;

   modport master (output req, input resp, input err);
   modport slave  (input req, output resp, output err);
endinterface

// File: rtl/iob_native_ram_responder.sv
// IOb native responder serving one request at a time from a byte-lane RAM with WAIT_CYCLES extra latency.
// Define IOB_NATIVE_RAM_RESPONDER_RANGE_EN to drop/flag accesses with nonzero address bits above the RAM.
module iob_native_ram_responder #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_ADDR_W  = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                      clk,
   input  logic                      resetn,
   iob_native_ram_responder_if.slave bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int DEPTH  = 1 << MEM_ADDR_W;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

   generate
      if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
         $error("WAIT_CYCLES must be in 0..15 (4-bit counter)");
      end
   endgenerate

   logic                  avalid;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [STRB_W-1:0]     wstrb;
   logic [MEM_ADDR_W-1:0] req_idx;
   logic                  req_is_read;
   logic                  req_oor;
   logic                  unused_bits;

   assign {avalid, addr, wdata, wstrb} = bus.req;
   assign req_idx     = addr[MEM_ADDR_W+1:2];
   assign req_is_read = (wstrb == '0);

`ifdef IOB_NATIVE_RAM_RESPONDER_RANGE_EN
   assign req_oor     = |addr[ADDR_W-1:MEM_ADDR_W+2];
   assign unused_bits = ^addr[1:0];
`else
   // Upper bits are ignored, so the RAM aliases across the full address space.
   assign req_oor     = 1'b0;
   assign unused_bits = ^{addr[ADDR_W-1:MEM_ADDR_W+2], addr[1:0]};
`endif

   logic [1:0]            state_reg;
   logic [3:0]            cnt_reg;
   logic                  is_read_reg;
   logic                  oor_reg;
   logic [MEM_ADDR_W-1:0] idx_reg;

   logic                  ready;
   logic                  accept;
   logic                  wr_en;
   logic                  rd_en;
   logic                  rvalid;
   logic [MEM_ADDR_W-1:0] rd_idx;
   logic [DATA_W-1:0]     rd_word;
   logic [DATA_W-1:0]     rdata;

   assign ready  = resetn && (state_reg == ST_IDLE);
   assign accept = ready && avalid;
   assign wr_en  = accept && !req_is_read && !req_oor;

   // With no wait cycles RESP is entered on the acceptance edge, so the RAM is read from the live request.
   assign rd_en  = (WAIT_CYCLES == 0) ? (accept && req_is_read)
                                      : ((state_reg == ST_WAIT) && (cnt_reg == 4'd1) && is_read_reg);
   assign rd_idx = (WAIT_CYCLES == 0) ? req_idx : idx_reg;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg   <= ST_IDLE;
         cnt_reg     <= 4'd0;
         is_read_reg <= 1'b0;
         oor_reg     <= 1'b0;
         idx_reg     <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (accept) begin
                  is_read_reg <= req_is_read;
                  oor_reg     <= req_oor;
                  idx_reg     <= req_idx;
                  cnt_reg     <= WAIT_INIT;
                  state_reg   <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (cnt_reg == 4'd1) begin
                  state_reg <= ST_RESP;
               end else begin
                  cnt_reg <= cnt_reg - 4'd1;
               end
            end
            ST_RESP: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < STRB_W; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] rd_q;

         always_ff @(posedge clk) begin
            if (wr_en && wstrb[gi]) begin
               mem[req_idx] <= wdata[gi*8 +: 8];
            end
            if (rd_en) begin
               rd_q <= mem[rd_idx];
            end
         end

         assign rd_word[gi*8 +: 8] = rd_q;
      end
   endgenerate

   assign rvalid   = (state_reg == ST_RESP);
   assign rdata    = (rvalid && is_read_reg && !oor_reg) ? rd_word : '0;
   assign bus.resp = {rdata, rvalid, ready};
   assign bus.err  = rvalid && oor_reg;

endmodule

// File: tb/tb_iob_native_ram_responder.sv
// Bench for iob_native_ram_responder: three instances (WAIT_CYCLES 1, 0, 5) checked against a
// word-array reference model; honours IOB_NATIVE_RAM_RESPONDER_RANGE_EN when defined.
module tb_iob_native_ram_responder;
   localparam int NU = 3;
   localparam int W0 = 1;
   localparam int W1 = 0;
   localparam int W2 = 5;
`ifdef IOB_NATIVE_RAM_RESPONDER_RANGE_EN
   localparam bit RANGE_ON = 1'b1;
`else
   localparam bit RANGE_ON = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        resetn_d [NU];
   logic        avalid_d [NU];
   logic [31:0] addr_d   [NU];
   logic [31:0] wdata_d  [NU];
   logic [3:0]  wstrb_d  [NU];
   logic [31:0] rdata_m  [NU];
   logic        rvalid_m [NU];
   logic        ready_m  [NU];
   logic        err_m    [NU];
   int          waits    [NU] = '{W0, W1, W2};

   iob_native_ram_responder_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
   iob_native_ram_responder_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
   iob_native_ram_responder_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

   assign bus0.req = {avalid_d[0], addr_d[0], wdata_d[0], wstrb_d[0]};
   assign bus1.req = {avalid_d[1], addr_d[1], wdata_d[1], wstrb_d[1]};
   assign bus2.req = {avalid_d[2], addr_d[2], wdata_d[2], wstrb_d[2]};
   assign {rdata_m[0], rvalid_m[0], ready_m[0]} = bus0.resp;
   assign {rdata_m[1], rvalid_m[1], ready_m[1]} = bus1.resp;
   assign {rdata_m[2], rvalid_m[2], ready_m[2]} = bus2.resp;
   assign err_m[0] = bus0.err;
   assign err_m[1] = bus1.err;
   assign err_m[2] = bus2.err;

   iob_native_ram_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .WAIT_CYCLES(W0)) u_dut0 (
      .clk(clk), .resetn(resetn_d[0]), .bus(bus0));
   iob_native_ram_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .WAIT_CYCLES(W1)) u_dut1 (
      .clk(clk), .resetn(resetn_d[1]), .bus(bus1));
   iob_native_ram_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .WAIT_CYCLES(W2)) u_dut2 (
      .clk(clk), .resetn(resetn_d[2]), .bus(bus2));

   int tests = 0;
   int fails = 0;
   int pulses = 0;

   logic [31:0] ref_mem [NU][1024];

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;
   vec_t vecs [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int u);
      @(negedge clk);
      if (rvalid_m[u] === 1'b1) pulses++;
   endtask

   // Issue one request on instance u and wait (bounded) for its response.
   task automatic xact(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic e);
      bit got;
      int lat;
      got = 1'b0;
      lat = 0;
      rd  = '0;
      e   = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (ready_m[u] === 1'b1) got = 1'b1;
      end
      check("ready_before_req", 32'(got), 32'd1);
      avalid_d[u] = 1'b1;
      addr_d[u]   = a;
      wdata_d[u]  = d;
      wstrb_d[u]  = s;
      @(posedge clk);
      #1;
      avalid_d[u] = 1'b0;
      wstrb_d[u]  = 4'h0;
      got = 1'b0;
      for (int i = 1; i <= 40 && !got; i++) begin
         @(negedge clk);
         if (rvalid_m[u] === 1'b1) begin
            got = 1'b1;
            lat = i;
            rd  = rdata_m[u];
            e   = err_m[u];
         end else begin
            check("rdata_zero_when_idle", rdata_m[u], 32'h0);
            check("err_zero_when_idle", 32'(err_m[u]), 32'h0);
         end
      end
      check("rvalid_seen", 32'(got), 32'd1);
      check("latency", 32'(lat), 32'(waits[u] + 1));
      @(negedge clk);
      check("rvalid_single_cycle", 32'(rvalid_m[u]), 32'h0);
      $display("[TB] u%0d W=%0d addr=%h wdata=%h wstrb=%h -> rdata=%h err=%b lat=%0d",
               u, waits[u], a, d, s, rd, e, lat);
   endtask

   // Reference behaviour straight from the access rules: word-array RAM, byte-lane writes.
   task automatic model_xact(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [31:0] exp_rd, output logic exp_e);
      bit oor;
      int idx;
      oor    = RANGE_ON && (a[31:12] != 20'h0);
      idx    = int'(a[11:2]);
      exp_e  = oor;
      exp_rd = 32'h0;
      if (s == 4'h0) begin
         if (!oor) exp_rd = ref_mem[u][idx];
      end else if (!oor) begin
         for (int b = 0; b < 4; b++) begin
            if (s[b]) ref_mem[u][idx][8*b +: 8] = d[8*b +: 8];
         end
      end
   endtask

   task automatic run_checked(input int u, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] er, ar;
      logic        ee, ae;
      model_xact(u, a, d, s, er, ee);
      xact(u, a, d, s, ar, ae);
      check("rand_rdata", ar, er);
      check("rand_err", 32'(ae), 32'(ee));
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      logic        e;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [31:0] hw [4];
      int          pcyc [4];
      bit          got;

      hw[0] = 32'h1111_0000;
      hw[1] = 32'h2222_0004;
      hw[2] = 32'h3333_0008;
      hw[3] = 32'h4444_000C;

      vecs[0] = '{"wr_full",    32'h10,   32'h1234_5678, 4'hF, 32'h0,         1'b0};
      vecs[1] = '{"rd_full",    32'h10,   32'h0,         4'h0, 32'h1234_5678, 1'b0};
      vecs[2] = '{"wr_byte2",   32'h10,   32'h00AB_0000, 4'h4, 32'h0,         1'b0};
      vecs[3] = '{"rd_merged",  32'h10,   32'h0,         4'h0, 32'h12AB_5678, 1'b0};
      vecs[4] = '{"wr_word0",   32'h0,    32'h1111_1111, 4'hF, 32'h0,         1'b0};
      vecs[5] = '{"wr_high",    32'h1000, 32'hAAAA_5555, 4'hF, 32'h0,         RANGE_ON};
      vecs[6] = '{"rd_word0",   32'h0,    32'h0,         4'h0,
                  RANGE_ON ? 32'h1111_1111 : 32'hAAAA_5555, 1'b0};
      vecs[7] = '{"rd_high",    32'h1000, 32'h0,         4'h0,
                  RANGE_ON ? 32'h0 : 32'hAAAA_5555, RANGE_ON};

      // Reset with a pending request on every instance.
      for (int u = 0; u < NU; u++) begin
         resetn_d[u] = 1'b0;
         avalid_d[u] = 1'b1;
         addr_d[u]   = 32'h40;
         wdata_d[u]  = 32'hDEAD_BEEF;
         wstrb_d[u]  = 4'hF;
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         for (int u = 0; u < NU; u++) begin
            check("reset_ready", 32'(ready_m[u]), 32'h0);
            check("reset_rvalid", 32'(rvalid_m[u]), 32'h0);
            check("reset_rdata", rdata_m[u], 32'h0);
            check("reset_err", 32'(err_m[u]), 32'h0);
         end
      end
      for (int u = 0; u < NU; u++) begin
         resetn_d[u] = 1'b1;
         avalid_d[u] = 1'b0;
         wstrb_d[u]  = 4'h0;
      end
      #1;
      for (int u = 0; u < NU; u++) check("ready_after_reset", 32'(ready_m[u]), 32'h1);
      pulses = 0;
      for (int c = 0; c < 3; c++) step(0);
      check("no_accept_in_reset", 32'(pulses), 32'h0);

      // Directed table on the WAIT_CYCLES=1 instance.
      for (int i = 0; i < 8; i++) begin
         xact(0, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, e);
         check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
         check({vecs[i].name, "_err"}, 32'(e), 32'(vecs[i].exp_err));
      end

      // Held-avalid initiator on the WAIT_CYCLES=0 instance.
      pulses = 0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         addr_d[1]   = 32'(k * 4);
         wdata_d[1]  = hw[k];
         wstrb_d[1]  = 4'hF;
         avalid_d[1] = 1'b1;
         got = 1'b0;
         pcyc[k] = 0;
         for (int i = 0; i < 10 && !got; i++) begin
            step(1);
            if (rvalid_m[1] === 1'b1) begin
               got = 1'b1;
               pcyc[k] = cyc;
            end
         end
         check("held_rvalid_seen", 32'(got), 32'h1);
         step(1);
         avalid_d[1] = 1'b0;
         step(1);
      end
      wstrb_d[1] = 4'h0;
      for (int c = 0; c < 4; c++) step(1);
      check("held_pulse_count", 32'(pulses), 32'd4);
      for (int k = 1; k < 4; k++) check("held_spacing", 32'(pcyc[k] - pcyc[k-1]), 32'd3);
      for (int k = 0; k < 4; k++) begin
         xact(1, 32'(k * 4), 32'h0, 4'h0, rd, e);
         check("held_readback", rd, hw[k]);
      end

      // Reset in the middle of WAIT on the WAIT_CYCLES=5 instance.
      pulses = 0;
      @(negedge clk);
      addr_d[2]   = 32'h20;
      wdata_d[2]  = 32'hCAFE_F00D;
      wstrb_d[2]  = 4'hF;
      avalid_d[2] = 1'b1;
      @(posedge clk);
      #1;
      avalid_d[2] = 1'b0;
      wstrb_d[2]  = 4'h0;
      @(posedge clk);
      @(posedge clk);
      #1;
      resetn_d[2] = 1'b0;
      step(2);
      check("midwait_reset_ready", 32'(ready_m[2]), 32'h0);
      step(2);
      resetn_d[2] = 1'b1;
      for (int c = 0; c < 10; c++) step(2);
      check("midwait_no_rvalid", 32'(pulses), 32'h0);
      xact(2, 32'h20, 32'h0, 4'h0, rd, e);
      check("midwait_write_kept", rd, 32'hCAFE_F00D);

      // Randomised traffic against the reference model.
      for (int u = 0; u < NU; u++) begin
         for (int w = 0; w < 32; w++) run_checked(u, 32'(w * 4), $urandom, 4'hF);
         for (int n = 0; n < 40; n++) begin
            a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
            d = $urandom;
            s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            run_checked(u, a, d, s);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
